pass_seq: RTL and testbench

Parametrised training-pass sequencer for the accelerator datapath. It steps through NUM_LAYERS forward passes in ascending layer order, then the backward passes in descending order, and repeats this for a run-time number of epochs. Each pass is a start/done handshake with the datapath. It sits between the top-level control (start, abort and epoch count) and the layer compute units, and replaces the fixed two-layer init/f0/end sequencer.

---
 rtl/pass_seq_pkg.sv | 11 +
 rtl/pass_seq_wdt.sv | 31 +++
 rtl/pass_seq.sv | 135 +++++++++++++
 tb/tb_pass_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pass_seq_pkg.sv
// Shared state codes for the training-pass sequencer and its debug mux.
package pass_seq_pkg;

  localparam int         ST_W    = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FWD  = 3'd1;
  localparam logic [2:0] ST_BWD  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/pass_seq_wdt.sv
// Per-pass watchdog: saturating cycle counter with clear/enable and an expired flag.
module pass_seq_wdt #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Flag one count early so the owner leaves on the edge the count would hit LIMIT.
  assign expired_o = (r_cnt >= CNT_W'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      if (clr_i)
        r_cnt <= '0;
      else if (cnt_en_i && !expired_o)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pass_seq.sv
// Training-pass sequencer: forward layers ascending, backward descending, per epoch.
// Optional per-pass watchdog enabled by defining PASS_SEQ_WDT_EN.
module pass_seq
  import pass_seq_pkg::*;
#(
  parameter  int NUM_LAYERS  = 2,
  parameter  int EPOCH_W     = 8,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  input  logic               pass_done_i,
  input  logic               abort_i,
  input  logic               ack_i,
  output logic               fwd_o,
  output logic               bwd_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [ST_W-1:0]    state_o
);

  logic [ST_W-1:0]    r_state;
  logic [LAYER_W-1:0] r_layer;
  logic [EPOCH_W-1:0] r_epoch;
  logic [EPOCH_W-1:0] r_epochs;

  logic w_busy;
  logic w_last_layer;
  logic w_last_epoch;
  logic w_wdt_exp;

  assign w_busy       = (r_state == ST_FWD) || (r_state == ST_BWD);
  assign w_last_layer = (r_layer == LAYER_W'(NUM_LAYERS - 1));
  assign w_last_epoch = (r_epoch == (r_epochs - EPOCH_W'(1)));

`ifdef PASS_SEQ_WDT_EN
  logic w_wdt_clr;

  // Held clear outside FWD/BWD so every pass entry starts from zero.
  assign w_wdt_clr = !w_busy || pass_done_i;

  pass_seq_wdt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .clr_i     (w_wdt_clr),
    .cnt_en_i  (w_busy),
    .expired_o (w_wdt_exp)
  );
`else
  assign w_wdt_exp = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_layer  <= '0;
      r_epoch  <= '0;
      r_epochs <= '0;
    end else if (en_i) begin
      if (abort_i) begin
        r_state <= ST_IDLE;
        r_layer <= '0;
        r_epoch <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (start_i) begin
            r_epochs <= epochs_i;
            r_layer  <= '0;
            r_epoch  <= '0;
            r_state  <= (epochs_i == '0) ? ST_DONE : ST_FWD;
          end
          ST_FWD: begin
            if (w_wdt_exp)
              r_state <= ST_ERR;
            else if (pass_done_i) begin
              if (w_last_layer) r_state <= ST_BWD;
              else              r_layer <= r_layer + 1'b1;
            end
          end
          ST_BWD: begin
            if (w_wdt_exp)
              r_state <= ST_ERR;
            else if (pass_done_i) begin
              if (r_layer != '0)
                r_layer <= r_layer - 1'b1;
              else if (w_last_epoch)
                r_state <= ST_DONE;
              else begin
                r_epoch <= r_epoch + 1'b1;
                r_state <= ST_FWD;
              end
            end
          end
          ST_DONE: if (ack_i) begin
            r_state <= ST_IDLE;
            r_layer <= '0;
            r_epoch <= '0;
          end
`ifdef PASS_SEQ_WDT_EN
          ST_ERR: ;
`endif
          default: begin
            r_state <= ST_IDLE;
            r_layer <= '0;
            r_epoch <= '0;
          end
        endcase
      end
    end
  end

  assign fwd_o   = (r_state == ST_FWD);
  assign bwd_o   = (r_state == ST_BWD);
  assign busy_o  = w_busy;
  assign done_o  = (r_state == ST_DONE);
`ifdef PASS_SEQ_WDT_EN
  assign err_o   = (r_state == ST_ERR);
`else
  assign err_o   = 1'b0;
`endif
  assign layer_o = r_layer;
  assign epoch_o = r_epoch;
  assign state_o = r_state;

endmodule

// File: tb/tb_pass_seq.sv
// Scoreboard bench for pass_seq: expected pass order queued at start, checked per pass.
module tb_pass_seq;

  localparam int NL = 3;
  localparam int EW = 8;
  localparam int LW = 2;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b1;
  logic          start_i = 1'b0;
  logic [EW-1:0] epochs_i = '0;
  logic          pass_done_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          ack_i = 1'b0;
  logic          fwd_o, bwd_o, busy_o, done_o, err_o;
  logic [LW-1:0] layer_o;
  logic [EW-1:0] epoch_o;
  logic [2:0]    state_o;

  pass_seq #(.NUM_LAYERS(NL), .EPOCH_W(EW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
    .epochs_i(epochs_i), .pass_done_i(pass_done_i), .abort_i(abort_i),
    .ack_i(ack_i), .fwd_o(fwd_o), .bwd_o(bwd_o), .layer_o(layer_o),
    .epoch_o(epoch_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          fwd;
    logic [LW-1:0] layer;
    logic [EW-1:0] epoch;
  } pass_t;

  pass_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_run(input int e);
    for (int ep = 0; ep < e; ep++) begin
      for (int l = 0; l < NL; l++)
        exp_q.push_back('{fwd: 1'b1, layer: LW'(l), epoch: EW'(ep)});
      for (int l = NL - 1; l >= 0; l--)
        exp_q.push_back('{fwd: 1'b0, layer: LW'(l), epoch: EW'(ep)});
    end
  endtask

  task automatic start_run(input int e);
    epochs_i = EW'(e);
    start_i  = 1'b1;
    push_run(e);
    tick();
    start_i  = 1'b0;
  endtask

  // Check the visible pass against the queue head, then complete it 3 cycles later.
  task automatic do_passes(input int n);
    pass_t p;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(1), 32'(0));
        return;
      end
      p = exp_q.pop_front();
      chk("pass_fwd",   32'(fwd_o),   32'(p.fwd));
      chk("pass_bwd",   32'(bwd_o),   32'(!p.fwd));
      chk("pass_layer", 32'(layer_o), 32'(p.layer));
      chk("pass_epoch", 32'(epoch_o), 32'(p.epoch));
      chk("pass_busy",  32'(busy_o),  32'(1));
      tick();
      tick();
      pass_done_i = 1'b1;
      tick();
      pass_done_i = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(0));
    chk({tag, "_outs"},  32'({fwd_o, bwd_o, busy_o, done_o, err_o}), 32'(0));
    chk({tag, "_layer"}, 32'(layer_o), 32'(0));
    chk({tag, "_epoch"}, 32'(epoch_o), 32'(0));
  endtask

  initial begin
    tick();
    tick();
    chk_zero("reset");
    rst_i = 1'b0;
    tick();

    // Full 2-epoch run on 3 layers: 12 passes then DONE with epoch 1.
    start_run(2);
    do_passes(12);
    chk("run_done",       32'(done_o),  32'(1));
    chk("run_done_state", 32'(state_o), 32'(3));
    chk("run_done_epoch", 32'(epoch_o), 32'(1));
    chk("run_done_fwd",   32'(fwd_o | bwd_o | busy_o), 32'(0));
    chk("sb_drain",       32'(exp_q.size()), 32'(0));
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("done_ign_start", 32'(state_o), 32'(3));
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("ack_idle", 32'(state_o), 32'(0));

    // Zero epochs goes straight to DONE.
    start_run(0);
    chk("zero_ep_state", 32'(state_o), 32'(3));
    chk("zero_ep_busy",  32'(busy_o),  32'(0));
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("zero_ep_ack", 32'(state_o), 32'(0));

    // Abort wins over pass_done during B1 of epoch 0.
    start_run(2);
    do_passes(4);
    chk("abort_pre_bwd",   32'(bwd_o),   32'(1));
    chk("abort_pre_layer", 32'(layer_o), 32'(1));
    abort_i     = 1'b1;
    pass_done_i = 1'b1;
    tick();
    abort_i     = 1'b0;
    pass_done_i = 1'b0;
    chk_zero("abort");
    exp_q.delete();
    start_run(1);
    do_passes(6);
    chk("rerun_done", 32'(done_o), 32'(1));
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;

    // Disabled cycles ignore pass_done; one enabled pulse advances exactly once.
    start_run(1);
    do_passes(1);
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pass_done_i = (i % 2 == 0);
      tick();
      chk("en_hold_state", 32'(state_o), 32'(1));
      chk("en_hold_layer", 32'(layer_o), 32'(1));
    end
    en_i        = 1'b1;
    pass_done_i = 1'b1;
    tick();
    pass_done_i = 1'b0;
    chk("en_adv_fwd",   32'(fwd_o),   32'(1));
    chk("en_adv_layer", 32'(layer_o), 32'(2));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    exp_q.delete();

    // Reset during BWD overrides en_i=0.
    start_run(1);
    do_passes(3);
    chk("rst_pre_bwd", 32'(bwd_o), 32'(1));
    en_i  = 1'b0;
    rst_i = 1'b1;
    tick();
    chk_zero("rst_bwd");
    rst_i = 1'b0;
    en_i  = 1'b1;
    exp_q.delete();
    tick();

`ifdef PASS_SEQ_WDT_EN
    // No pass_done after start: ERR after TO busy cycles, abort clears it.
    start_run(1);
    for (int i = 1; i < TO; i++) tick();
    chk("wdt_pre_err",  32'(err_o),  32'(0));
    chk("wdt_pre_busy", 32'(busy_o), 32'(1));
    tick();
    chk("wdt_err",       32'(err_o),   32'(1));
    chk("wdt_err_state", 32'(state_o), 32'(4));
    tick();
    chk("wdt_err_hold",  32'(err_o),   32'(1));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk_zero("wdt_abort");
    exp_q.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
